// File: rtl/ff_pkg.sv
// ff_pkg: shared types and constants for the foodfight
// external SRAM arbiter.
package ff_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACC,
    ST_ACK
  } ff_state_t;

  localparam int RQ_VID = 0;
  localparam int RQ_MO  = 1;
  localparam int RQ_CPU = 2;
  localparam int NRQ    = 3;

  localparam int FF_AW      = 16;
  localparam int FF_DW      = 16;
  localparam int FF_WAIT    = 2;
  localparam int FF_CPU_MAX = 3;

endpackage

// File: rtl/ff_arb_pick.sv
// ff_arb_pick: combinational one-hot winner selection,
// VID > MO > CPU unless the CPU has been starved.
module ff_arb_pick
  import ff_pkg::*;
(
  input  logic           vid_req,
  input  logic           mo_req,
  input  logic           cpu_req,
  input  logic           starve,
  output logic [NRQ-1:0] grant
);

  always_comb begin
    grant = '0;
    priority case (1'b1)
      cpu_req && starve: grant[RQ_CPU] = 1'b1;
      vid_req:           grant[RQ_VID] = 1'b1;
      mo_req:            grant[RQ_MO]  = 1'b1;
      cpu_req:           grant[RQ_CPU] = 1'b1;
      default:           grant = '0;
    endcase
  end

endmodule

// File: rtl/ff_mem_arb.sv
// ff_mem_arb: arbitrates VID, MO and CPU onto one shared
// single-port SRAM and sequences the access timing.
module ff_mem_arb
  import ff_pkg::*;
#(
  parameter int AW      = FF_AW,
  parameter int DW      = FF_DW,
  parameter int WAIT    = FF_WAIT,
  parameter int CPU_MAX = FF_CPU_MAX
) (
  input  logic          clk_12mhz,
  input  logic          reset,
  input  logic          vid_req,
  input  logic          mo_req,
  input  logic          cpu_req,
  input  logic [AW-1:0] vid_addr,
  input  logic [AW-1:0] mo_addr,
  input  logic [AW-1:0] cpu_addr,
  input  logic          cpu_we,
  input  logic [DW-1:0] cpu_wdata,
  output logic          vid_ack,
  output logic          mo_ack,
  output logic          cpu_ack,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] sram_a,
  output logic [DW-1:0] sram_dout,
  output logic          sram_doe,
  input  logic [DW-1:0] sram_din,
  output logic          sram_ce,
  output logic          sram_we
);

  localparam int SW = $clog2(CPU_MAX + 1);
  localparam logic [2:0] LAST = 3'(WAIT - 1);
  localparam logic [SW-1:0] SMAX = SW'(CPU_MAX);

  ff_state_t      state_q, state_d;
  logic [2:0]     cnt_q, cnt_d, cnt_nx;
  logic [NRQ-1:0] gnt_q, gnt_d;
  logic           wr_q, wr_d;
  logic [SW-1:0]  starve_q, starve_d;
  logic [NRQ-1:0] ack_q, ack_d;
  logic [DW-1:0]  rdata_q, rdata_d;
  logic [AW-1:0]  a_q, a_d;
  logic [DW-1:0]  dout_q, dout_d;
  logic           doe_q, doe_d;
  logic           ce_q, ce_d;
  logic           swe_q, swe_d;
  logic [NRQ-1:0] pick;
  logic           starve;

  assign starve = (starve_q == SMAX);
  assign cnt_nx = cnt_q + 3'd1;

  ff_arb_pick u_pick (
    .vid_req (vid_req),
    .mo_req  (mo_req),
    .cpu_req (cpu_req),
    .starve  (starve),
    .grant   (pick)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    gnt_d    = gnt_q;
    wr_d     = wr_q;
    starve_d = starve_q;
    ack_d    = '0;
    rdata_d  = rdata_q;
    a_d      = a_q;
    dout_d   = dout_q;
    doe_d    = 1'b0;
    ce_d     = 1'b0;
    swe_d    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (|pick) begin
          state_d = ST_ACC;
          cnt_d   = '0;
          gnt_d   = pick;
          wr_d    = 1'b0;
          unique case (1'b1)
            pick[RQ_VID]: a_d = vid_addr;
            pick[RQ_MO]:  a_d = mo_addr;
            pick[RQ_CPU]: begin
              a_d    = cpu_addr;
              wr_d   = cpu_we;
              dout_d = cpu_wdata;
            end
            default: ;
          endcase
          ce_d  = 1'b1;
          swe_d = wr_d;
          doe_d = wr_d;
          if (cpu_req) begin
            if (pick[RQ_CPU])
              starve_d = '0;
            else if (!starve)
              starve_d = starve_q + 1'b1;
          end
        end
      end
      ST_ACC: begin
        if (cnt_q == LAST) begin
          state_d = ST_ACK;
          ack_d   = gnt_q;
          if (!wr_q)
            rdata_d = sram_din;
        end else begin
          cnt_d = cnt_nx;
          ce_d  = 1'b1;
          doe_d = wr_q;
          // strobe drops one cycle early so data holds past we
          swe_d = wr_q && (cnt_nx != LAST);
        end
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_12mhz or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      gnt_q    <= '0;
      wr_q     <= 1'b0;
      starve_q <= '0;
      ack_q    <= '0;
      rdata_q  <= '0;
      a_q      <= '0;
      dout_q   <= '0;
      doe_q    <= 1'b0;
      ce_q     <= 1'b0;
      swe_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      gnt_q    <= gnt_d;
      wr_q     <= wr_d;
      starve_q <= starve_d;
      ack_q    <= ack_d;
      rdata_q  <= rdata_d;
      a_q      <= a_d;
      dout_q   <= dout_d;
      doe_q    <= doe_d;
      ce_q     <= ce_d;
      swe_q    <= swe_d;
    end
  end

  assign vid_ack   = ack_q[RQ_VID];
  assign mo_ack    = ack_q[RQ_MO];
  assign cpu_ack   = ack_q[RQ_CPU];
  assign rdata     = rdata_q;
  assign sram_a    = a_q;
  assign sram_dout = dout_q;
  assign sram_doe  = doe_q;
  assign sram_ce   = ce_q;
  assign sram_we   = swe_q;

endmodule

// File: tb/tb_ff_mem_arb.sv
// tb_ff_mem_arb: table vectors, directed corner sequences and a
// randomized run against a transaction-level reference model.
module tb_ff_mem_arb;
  import ff_pkg::*;

  localparam int AW      = 16;
  localparam int DW      = 16;
  localparam int WAIT    = 2;
  localparam int CPU_MAX = 3;

  logic          clk_12mhz = 1'b0;
  logic          reset = 1'b1;
  logic          vid_req, mo_req, cpu_req;
  logic [AW-1:0] vid_addr, mo_addr, cpu_addr;
  logic          cpu_we;
  logic [DW-1:0] cpu_wdata;
  logic          vid_ack, mo_ack, cpu_ack;
  logic [DW-1:0] rdata;
  logic [AW-1:0] sram_a;
  logic [DW-1:0] sram_dout;
  logic          sram_doe;
  logic [DW-1:0] sram_din = '0;
  logic          sram_ce, sram_we;
  logic [2:0]    ackv;

  always #5 clk_12mhz = ~clk_12mhz;

  ff_mem_arb #(
    .AW(AW), .DW(DW), .WAIT(WAIT), .CPU_MAX(CPU_MAX)
  ) dut (
    .clk_12mhz (clk_12mhz),
    .reset     (reset),
    .vid_req   (vid_req),
    .mo_req    (mo_req),
    .cpu_req   (cpu_req),
    .vid_addr  (vid_addr),
    .mo_addr   (mo_addr),
    .cpu_addr  (cpu_addr),
    .cpu_we    (cpu_we),
    .cpu_wdata (cpu_wdata),
    .vid_ack   (vid_ack),
    .mo_ack    (mo_ack),
    .cpu_ack   (cpu_ack),
    .rdata     (rdata),
    .sram_a    (sram_a),
    .sram_dout (sram_dout),
    .sram_doe  (sram_doe),
    .sram_din  (sram_din),
    .sram_ce   (sram_ce),
    .sram_we   (sram_we)
  );

  assign ackv = {cpu_ack, mo_ack, vid_ack};

  // behavioural SRAM: unwritten words read a fixed pattern
  logic [DW-1:0] mem [0:65535];
  bit            wv  [0:65535];

  function automatic logic [DW-1:0] dflt(input logic [AW-1:0] a);
    return (a == 16'h1234) ? 16'hBEEF : (a ^ 16'h5A5A);
  endfunction

  always @(posedge clk_12mhz)
    if (sram_ce && sram_we) begin
      mem[sram_a] <= sram_dout;
      wv[sram_a]  <= 1'b1;
    end

  always @(negedge clk_12mhz)
    sram_din <= wv[sram_a] ? mem[sram_a] : dflt(sram_a);

  logic [DW-1:0] ref_mem [int];

  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : dflt(a);
  endfunction

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_12mhz);
    #1;
  endtask

  task automatic clr_in;
    vid_req = 0; mo_req = 0; cpu_req = 0;
    vid_addr = '0; mo_addr = '0; cpu_addr = '0;
    cpu_we = 0; cpu_wdata = '0;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    clr_in();
    tick();
    chk("rst_ctl", {ackv, sram_doe, sram_ce, sram_we}, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_a", sram_a, 0);
    chk("rst_dout", sram_dout, 0);
    reset = 1'b0;
    tick();
  endtask

  typedef struct {
    logic [2:0]    mask;
    logic [2:0]    exp_ack;
    logic [AW-1:0] exp_addr;
  } vec_t;

  vec_t          vt [7];
  int            c;
  logic [2:0]    rq, ex, just;
  logic [AW-1:0] raddr [3];
  logic          rwe;
  logic [DW-1:0] rwd;
  int            nf, pcyc, pidx, starve, w;
  bit            pv, prd;
  logic [DW-1:0] pdat;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    clr_in();
    vt[0] = '{3'b001, 3'b001, 16'h0100};
    vt[1] = '{3'b010, 3'b010, 16'h0200};
    vt[2] = '{3'b100, 3'b100, 16'h0300};
    vt[3] = '{3'b011, 3'b001, 16'h0100};
    vt[4] = '{3'b110, 3'b010, 16'h0200};
    vt[5] = '{3'b101, 3'b001, 16'h0100};
    vt[6] = '{3'b111, 3'b001, 16'h0100};

    for (int i = 0; i < 7; i++) begin
      do_reset();
      vid_req = vt[i].mask[0]; vid_addr = 16'h0100;
      mo_req  = vt[i].mask[1]; mo_addr  = 16'h0200;
      cpu_req = vt[i].mask[2]; cpu_addr = 16'h0300;
      c = 1;
      tick();
      while (ackv == 0 && c < 20) begin
        tick();
        c++;
      end
      chk("vec_lat", c, WAIT + 1);
      chk("vec_ack", ackv, vt[i].exp_ack);
      chk("vec_rdata", rdata, ref_rd(vt[i].exp_addr));
      clr_in();
      tick();
    end

    // lone CPU read
    do_reset();
    cpu_req = 1; cpu_addr = 16'h1234;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("rd_ce", sram_ce, (k == 1 || k == 2));
      chk("rd_we", sram_we, 0);
      chk("rd_ack", ackv, (k == 3) ? 3'b100 : 3'b000);
      if (k <= 2) chk("rd_a", sram_a, 16'h1234);
      if (k == 3) begin
        chk("rd_data", rdata, 16'hBEEF);
        cpu_req = 0;
      end
    end

    // CPU write then readback by VID
    do_reset();
    cpu_req = 1; cpu_addr = 16'h0010;
    cpu_we = 1; cpu_wdata = 16'hA5A5;
    ref_mem[16] = 16'hA5A5;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("wr_we", sram_we, (k == 1));
      chk("wr_doe", sram_doe, (k == 1 || k == 2));
      if (k <= 2) chk("wr_dout", sram_dout, 16'hA5A5);
      chk("wr_ack", ackv, (k == 3) ? 3'b100 : 3'b000);
      if (k == 3) clr_in();
    end
    vid_req = 1; vid_addr = 16'h0010;
    tick(); tick(); tick();
    chk("wr_rdback_ack", ackv, 3'b001);
    chk("wr_rdback", rdata, 16'hA5A5);
    clr_in();
    tick();

    // three simultaneous requests
    do_reset();
    vid_req = 1; mo_req = 1; cpu_req = 1;
    vid_addr = 16'h0040; mo_addr = 16'h0041; cpu_addr = 16'h0042;
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk("all3_ack", ackv,
          (k == 3) ? 3'b001 : (k == 7) ? 3'b010 :
          (k == 11) ? 3'b100 : 3'b000);
      if (vid_ack) vid_req = 0;
      if (mo_ack)  mo_req = 0;
      if (cpu_ack) cpu_req = 0;
    end

    // CPU starvation: wins every 4th arbitration
    do_reset();
    vid_req = 1; mo_req = 1; cpu_req = 1;
    for (int k = 1; k <= 32; k++) begin
      tick();
      chk("starve_ack", ackv,
          (k % 4 != 3) ? 3'b000 :
          (((k + 1) / 4) % 4 == 0) ? 3'b100 : 3'b001);
    end
    clr_in();
    tick(); tick(); tick(); tick();

    // MO drops its req during ACC
    do_reset();
    mo_req = 1; mo_addr = 16'h0020;
    tick();
    chk("drop_ce1", sram_ce, 1);
    mo_req = 0;
    for (int k = 2; k <= 10; k++) begin
      tick();
      chk("drop_ack", ackv, (k == 3) ? 3'b010 : 3'b000);
      chk("drop_ce", sram_ce, (k == 2));
    end

    // reset in the middle of a VID read
    do_reset();
    vid_req = 1; vid_addr = 16'h0030;
    tick();
    chk("mid_ce", sram_ce, 1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_ctl", {ackv, sram_doe, sram_ce, sram_we}, 0);
    chk("mid_rst_a", sram_a, 0);
    vid_req = 0;
    tick(); tick();
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("mid_noack", ackv, 0);
    end
    vid_req = 1; vid_addr = 16'h0031;
    c = 1;
    tick();
    while (ackv == 0 && c < 20) begin
      tick();
      c++;
    end
    chk("mid_lat", c, WAIT + 1);
    chk("mid_ack", ackv, 3'b001);
    chk("mid_rdata", rdata, ref_rd(16'h0031));
    clr_in();
    tick();

    // randomized traffic against a transaction-level model
    do_reset();
    rq = 0; nf = 0; pv = 0; starve = 0; rwe = 0; rwd = '0;
    for (int i = 0; i < 3; i++) raddr[i] = '0;
    for (int n = 0; n < 3000; n++) begin
      ex = (pv && pcyc == n) ? 3'(1 << pidx) : 3'b000;
      chk("rnd_ack", ackv, ex);
      just = 3'b000;
      if (ex != 0) begin
        if (prd) chk("rnd_rdata", rdata, pdat);
        rq[pidx] = 0;
        just = ex;
        pv = 0;
      end
      for (int i = 0; i < 3; i++)
        if (!rq[i] && !just[i] && $urandom_range(0, 3) == 0) begin
          rq[i] = 1;
          raddr[i] = 16'($urandom_range(0, 15));
          if (i == RQ_CPU) begin
            rwe = 1'($urandom_range(0, 1));
            rwd = 16'($urandom);
          end
        end
      vid_req = rq[RQ_VID]; vid_addr = raddr[RQ_VID];
      mo_req  = rq[RQ_MO];  mo_addr  = raddr[RQ_MO];
      cpu_req = rq[RQ_CPU]; cpu_addr = raddr[RQ_CPU];
      cpu_we = rwe; cpu_wdata = rwd;
      if (n >= nf && rq != 0) begin
        if (rq[RQ_CPU] && starve == CPU_MAX) w = RQ_CPU;
        else if (rq[RQ_VID]) w = RQ_VID;
        else if (rq[RQ_MO]) w = RQ_MO;
        else w = RQ_CPU;
        if (rq[RQ_CPU])
          starve = (w == RQ_CPU) ? 0 :
                   (starve < CPU_MAX) ? starve + 1 : starve;
        pv = 1;
        pidx = w;
        pcyc = n + WAIT + 1;
        prd = !(w == RQ_CPU && rwe);
        pdat = ref_rd(raddr[w]);
        if (!prd) ref_mem[int'(raddr[w])] = rwd;
        nf = n + WAIT + 2;
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ff_mem_arb.md
# ff_mem_arb

Arbiter and sequencer for the single shared external work/video SRAM in the foodfight FPGA build. It multiplexes three requesters onto one single-port SRAM:
- video playfield fetch (VID)
- motion-object fetch (MO)
- the 68000 CPU bus bridge (CPU)

It runs the SRAM access timing and returns read data with a one-cycle acknowledge. It sits between the CPU/video logic inside the game core and the board SRAM pins.

## Interface
Parameters:
- AW, 16, SRAM word-address width
- DW, 16, SRAM data width
- WAIT, 2, SRAM access cycles per transfer (legal 1..7)
- CPU_MAX, 3, lost arbitrations after which the CPU is forced to win

Ports:
- clk_12mhz  in  1  core clock; all logic on rising edge
- reset  in  1  asynchronous, active-high
- vid_req, mo_req, cpu_req  in  1 each  access request, held until ack
- vid_addr, mo_addr, cpu_addr  in  AW each  word address
- cpu_we  in  1  CPU write (VID and MO are read-only)
- cpu_wdata  in  DW  CPU write data
- vid_ack, mo_ack, cpu_ack  out  1 each  one-cycle completion pulse
- rdata  out  DW  read data, valid while any ack is high
- sram_a  out  AW  SRAM address
- sram_dout  out  DW  SRAM write data
- sram_doe  out  1  drive sram_dout onto the pad
- sram_din  in  DW  SRAM read data
- sram_ce, sram_we  out  1 each  active-high strobes; the top level inverts them for the pins

## Operation
- States:
  - IDLE: arbitrate.
  - ACC: SRAM cycle, counter runs 0..WAIT-1.
  - ACK: pulse the winner's ack.
- IDLE with at least one req:
  - Pick a winner.
  - Register its address, we and wdata.
  - Go to ACC, counter = 0.
- IDLE with no req: stay in IDLE.
- Priority: VID > MO > CPU, with one exception. If cpu_req is high and starve_cnt == CPU_MAX, the CPU wins.
- starve_cnt (width clog2(CPU_MAX+1)):
  - At each arbitration where cpu_req is high and the CPU loses, increment it, saturating at CPU_MAX.
  - Clear it when the CPU wins.
  - Arbitrations where cpu_req is low leave it unchanged.
- ACC:
  - sram_ce = 1 throughout; sram_a = latched address.
  - For a write: sram_we = 1 and sram_doe = 1, except on the final ACC cycle where sram_we = 0. When WAIT = 1, sram_we stays high for that single cycle.
  - For a read: on the final ACC cycle, capture sram_din into rdata.
  - After the final ACC cycle, go to ACK.
- ACK:
  - Pulse the winner's ack for exactly one cycle.
  - rdata holds the captured value; it is undefined-but-stable for writes, and holds the previous value.
  - sram_a holds; sram_ce, sram_we and sram_doe are 0.
  - Next state is IDLE.
- Requester contract: drop req on the clock edge that ends the ack cycle. A req still high in IDLE is a new request.
- A req dropped during ACC or ACK is ignored: the access completes and the ack is still issued.
- Requests raised during ACC or ACK wait for the next IDLE. There is no queueing beyond the req level.
- Only one ack is ever high at a time.

## Timing
- Reset values (asserted asynchronously; state goes to IDLE):
  - all acks 0, rdata 0, sram_a 0, sram_dout 0
  - sram_doe 0, sram_ce 0, sram_we 0
  - starve_cnt 0
- If reset arrives mid-access, the access is abandoned and no ack is issued.
- All outputs are registered. There is no combinational path from req to any output.
- Uncontended latency: req sampled in IDLE at cycle 0; ACC cycles 1..WAIT; ack at cycle WAIT+1.
- Throughput: one transfer per WAIT+2 cycles. With WAIT = 2 that is 4 cycles, i.e. 3 MHz at 12 MHz.
- Simultaneous reqs are resolved in the single IDLE cycle. Losers keep req high and are re-evaluated at the next IDLE.
- WAIT = 1: ACC lasts 1 cycle; the write strobe rule is as stated in Operation.

## Structure
- Shared package ff_pkg holds:
  - state enum: ST_IDLE, ST_ACC, ST_ACK
  - requester indices: RQ_VID = 0, RQ_MO = 1, RQ_CPU = 2
  - default SRAM geometry constants
- Sub-module ff_arb_pick: purely combinational winner selection. Inputs are the three reqs and the starvation flag; output is a one-hot grant. Sequencing, counters and the datapath stay in ff_mem_arb.

## Test plan
- Lone CPU read, addr 0x1234, sram_din = 0xBEEF, WAIT = 2 → sram_ce high for cycles 1–2; cpu_ack on cycle 3 with rdata = 0xBEEF; sram_we never high.
- CPU write, addr 0x0010, data 0xA5A5, WAIT = 2 → sram_we = 1 on cycle 1 only; sram_doe = 1 on cycles 1–2; sram_dout = 0xA5A5; cpu_ack on cycle 3.
- VID, MO and CPU requests all raised in the same cycle → ack order VID, MO, CPU, at cycles 3, 7, 11.
- VID and MO re-requesting continuously while cpu_req is held, CPU_MAX = 3 → the CPU wins the 4th arbitration; starve_cnt returns to 0.
- MO req dropped during ACC → mo_ack still pulses once; no second access is started.
- Reset asserted during ACC of a VID read → all outputs 0 immediately and no vid_ack; after reset release, a new req is served with normal latency.
